// File: rtl/priv_1_11_trap_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priv_1_11_trap_sequencer : M-mode trap entry / MRET sequencer (drain + commit)
// Revision 1.0
// ---------------------------------------------------------------------------
module priv_1_11_trap_sequencer #(
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_epc,
    input  logic [31:0] exc_tval,
    input  logic        irq_valid,
    input  logic [3:0]  irq_cause,
    input  logic [31:0] irq_epc,
    input  logic        mret_req,
    input  logic        pipe_clear,
    input  logic        mstatus_mie,
    input  logic        mstatus_mpie,
    output logic        busy,
    output logic        intr,
    output logic        mret,
    output logic        csr_wen,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic        mie_next,
    output logic        mpie_next,
    output logic        drain_err
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_TRAP_DRAIN  = 3'd1;
    localparam logic [2:0] S_TRAP_COMMIT = 3'd2;
    localparam logic [2:0] S_RET_DRAIN   = 3'd3;
    localparam logic [2:0] S_RET_COMMIT  = 3'd4;

    localparam logic [7:0] C_TIMEOUT = 8'(DRAIN_TIMEOUT);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_int_bit;
    logic [3:0]  r_cause;
    logic [31:2] r_epc;
    logic [31:0] r_tval;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        r_drain_err;
    logic        w_irq_take;
    logic        w_in_drain;

    assign w_irq_take = irq_valid & mstatus_mie;
    assign w_in_drain = (r_state == S_TRAP_DRAIN) || (r_state == S_RET_DRAIN);
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (exc_valid || w_irq_take) begin
                    w_state_next = S_TRAP_DRAIN;
                end else if (mret_req) begin
                    w_state_next = S_RET_DRAIN;
                end
            end
            S_TRAP_DRAIN:  if (pipe_clear) w_state_next = S_TRAP_COMMIT;
            S_RET_DRAIN:   if (pipe_clear) w_state_next = S_RET_COMMIT;
            S_TRAP_COMMIT: w_state_next = S_IDLE;
            S_RET_COMMIT:  w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // Trap latch, drain counter and sticky timeout flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_int_bit   <= 1'b0;
            r_cause     <= 4'd0;
            r_epc       <= '0;
            r_tval      <= 32'd0;
            r_cnt       <= 8'd0;
            r_drain_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= 8'd0;
                if (exc_valid) begin
                    r_int_bit <= 1'b0;
                    r_cause   <= exc_cause;
                    r_epc     <= exc_epc[31:2];
                    r_tval    <= exc_tval;
                end else if (w_irq_take) begin
                    r_int_bit <= 1'b1;
                    r_cause   <= irq_cause;
                    r_epc     <= irq_epc[31:2];
                    r_tval    <= 32'd0;
                end
            end
            // A synchronous exception outranks an interrupt still waiting to commit
            if ((r_state == S_TRAP_DRAIN) && exc_valid && r_int_bit) begin
                r_int_bit <= 1'b0;
                r_cause   <= exc_cause;
                r_epc     <= exc_epc[31:2];
                r_tval    <= exc_tval;
            end
            if (w_in_drain && !pipe_clear) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc >= C_TIMEOUT) begin
                    r_drain_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        intr      = 1'b0;
        mret      = 1'b0;
        csr_wen   = 1'b0;
        mie_next  = 1'b0;
        mpie_next = 1'b0;
        mcause_o  = {r_int_bit, 27'd0, r_cause};
        mepc_o    = {r_epc, 2'b00};
        mtval_o   = r_tval;
        drain_err = r_drain_err;
        case (r_state)
            S_TRAP_COMMIT: begin
                intr      = 1'b1;
                csr_wen   = 1'b1;
                mie_next  = 1'b0;
                mpie_next = mstatus_mie;
            end
            S_RET_COMMIT: begin
                mret      = 1'b1;
                csr_wen   = 1'b1;
                mie_next  = mstatus_mpie;
                mpie_next = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_priv_1_11_trap_sequencer.sv
`default_nettype none
// Bench for priv_1_11_trap_sequencer: transaction-level reference model plus directed scenarios.
module tb_priv_1_11_trap_sequencer;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        exc_valid = 1'b0;
    logic [3:0]  exc_cause = 4'd0;
    logic [31:0] exc_epc = 32'd0;
    logic [31:0] exc_tval = 32'd0;
    logic        irq_valid = 1'b0;
    logic [3:0]  irq_cause = 4'd0;
    logic [31:0] irq_epc = 32'd0;
    logic        mret_req = 1'b0;
    logic        pipe_clear = 1'b0;
    logic        mstatus_mie = 1'b0;
    logic        mstatus_mpie = 1'b0;
    logic        busy, intr, mret, csr_wen, mie_next, mpie_next, drain_err;
    logic [31:0] mcause_o, mepc_o, mtval_o;

    int n_checks = 0;
    int n_fail   = 0;

    priv_1_11_trap_sequencer #(.DRAIN_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_epc(exc_epc), .exc_tval(exc_tval),
        .irq_valid(irq_valid), .irq_cause(irq_cause), .irq_epc(irq_epc),
        .mret_req(mret_req), .pipe_clear(pipe_clear),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .busy(busy), .intr(intr), .mret(mret), .csr_wen(csr_wen),
        .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
        .mie_next(mie_next), .mpie_next(mpie_next), .drain_err(drain_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: pending kind (0 none, 1 trap, 2 return), drain/commit phase, trap record
    int          m_kind = 0;
    bit          m_drain = 0, m_commit = 0, m_err = 0;
    bit          m_int = 0;
    logic [3:0]  m_cause = 0;
    logic [31:0] m_epc = 0, m_tval = 0;
    int          m_wait = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_kind <= 0; m_drain <= 0; m_commit <= 0; m_err <= 0;
            m_int <= 0; m_cause <= 0; m_epc <= 0; m_tval <= 0; m_wait <= 0;
        end else if (m_commit) begin
            m_commit <= 0;
            m_kind   <= 0;
        end else if (m_drain) begin
            if (pipe_clear) begin
                m_drain  <= 0;
                m_commit <= 1;
            end else begin
                m_wait <= (m_wait + 1 > 255) ? 255 : m_wait + 1;
                if (m_wait + 1 >= TIMEOUT) m_err <= 1;
            end
            if (m_kind == 1 && exc_valid && m_int) begin
                m_int <= 0; m_cause <= exc_cause; m_epc <= exc_epc; m_tval <= exc_tval;
            end
        end else if (exc_valid) begin
            m_kind <= 1; m_drain <= 1; m_wait <= 0;
            m_int <= 0; m_cause <= exc_cause; m_epc <= exc_epc; m_tval <= exc_tval;
        end else if (irq_valid && mstatus_mie) begin
            m_kind <= 1; m_drain <= 1; m_wait <= 0;
            m_int <= 1; m_cause <= irq_cause; m_epc <= irq_epc; m_tval <= 0;
        end else if (mret_req) begin
            m_kind <= 2; m_drain <= 1; m_wait <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        bit trap_c, ret_c;
        trap_c = m_commit && (m_kind == 1);
        ret_c  = m_commit && (m_kind == 2);
        chk("model_busy", {31'd0, busy}, {31'd0, m_drain | m_commit});
        chk("model_intr", {31'd0, intr}, {31'd0, trap_c});
        chk("model_mret", {31'd0, mret}, {31'd0, ret_c});
        chk("model_csr_wen", {31'd0, csr_wen}, {31'd0, m_commit});
        chk("model_mcause", mcause_o, {m_int, 27'd0, m_cause});
        chk("model_mepc", mepc_o, m_epc & 32'hFFFF_FFFC);
        chk("model_mtval", mtval_o, m_tval);
        chk("model_mie_next", {31'd0, mie_next}, {31'd0, ret_c ? mstatus_mpie : 1'b0});
        chk("model_mpie_next", {31'd0, mpie_next}, {31'd0, trap_c ? mstatus_mie : ret_c});
        chk("model_drain_err", {31'd0, drain_err}, {31'd0, m_err});
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int n_intr, n_mret;
        repeat (2) tick();
        nRST = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_drain_err", {31'd0, drain_err}, 32'd0);
        tick();

        // Exception with pipeline already clear: commit two cycles after the request
        mstatus_mie = 1'b1; pipe_clear = 1'b1;
        exc_valid = 1'b1; exc_cause = 4'd2; exc_epc = 32'h100; exc_tval = 32'hDEAD;
        tick();
        exc_valid = 1'b0;
        chk("exc_drain_busy", {31'd0, busy}, 32'd1);
        chk("exc_drain_intr", {31'd0, intr}, 32'd0);
        tick();
        chk("exc_intr", {31'd0, intr}, 32'd1);
        chk("exc_csr_wen", {31'd0, csr_wen}, 32'd1);
        chk("exc_mcause", mcause_o, 32'h0000_0002);
        chk("exc_mepc", mepc_o, 32'h100);
        chk("exc_mtval", mtval_o, 32'hDEAD);
        chk("exc_mie_next", {31'd0, mie_next}, 32'd0);
        chk("exc_mpie_next", {31'd0, mpie_next}, 32'd1);
        tick();
        chk("exc_done_intr", {31'd0, intr}, 32'd0);
        chk("exc_done_busy", {31'd0, busy}, 32'd0);

        // Interrupt: interrupt bit set, tval zero, mepc low bits forced to zero
        irq_valid = 1'b1; irq_cause = 4'd11; irq_epc = 32'h2003;
        tick();
        irq_valid = 1'b0;
        tick();
        chk("irq_mcause", mcause_o, 32'h8000_000B);
        chk("irq_mepc", mepc_o, 32'h2000);
        chk("irq_mtval", mtval_o, 32'd0);
        tick();

        // Interrupt overtaken by an exception during its drain
        pipe_clear = 1'b0;
        irq_valid = 1'b1; irq_cause = 4'd7; irq_epc = 32'h300;
        tick();
        irq_valid = 1'b0;
        tick();
        exc_valid = 1'b1; exc_cause = 4'd4; exc_epc = 32'h400; exc_tval = 32'h44;
        tick();
        exc_valid = 1'b0;
        tick();
        pipe_clear = 1'b1;
        tick();
        chk("ovr_intr", {31'd0, intr}, 32'd1);
        chk("ovr_mcause", mcause_o, 32'h0000_0004);
        chk("ovr_mepc", mepc_o, 32'h400);
        tick();

        // Masked interrupt is not accepted
        mstatus_mie = 1'b0; irq_valid = 1'b1;
        tick(); tick();
        chk("masked_busy", {31'd0, busy}, 32'd0);
        irq_valid = 1'b0;

        // MRET: mstatus restore, data outputs keep last trap record
        mstatus_mpie = 1'b1; mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        tick();
        chk("ret_mret", {31'd0, mret}, 32'd1);
        chk("ret_intr", {31'd0, intr}, 32'd0);
        chk("ret_mie_next", {31'd0, mie_next}, 32'd1);
        chk("ret_mpie_next", {31'd0, mpie_next}, 32'd1);
        chk("ret_mcause_hold", mcause_o, 32'h0000_0004);
        tick();

        // Simultaneous requests: only the exception is serviced
        mstatus_mie = 1'b1;
        exc_valid = 1'b1; exc_cause = 4'd6; irq_valid = 1'b1; mret_req = 1'b1;
        tick();
        exc_valid = 1'b0; irq_valid = 1'b0; mret_req = 1'b0;
        n_intr = 0; n_mret = 0;
        for (int i = 0; i < 5; i++) begin
            n_intr += int'(intr);
            n_mret += int'(mret);
            tick();
        end
        chk("prio_intr_count", n_intr, 1);
        chk("prio_mret_count", n_mret, 0);

        // Long drain: timeout flag after the 16th stalled drain cycle, then normal commit
        pipe_clear = 1'b0; exc_valid = 1'b1; exc_cause = 4'd5;
        tick();
        exc_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) chk("tmo_err_before", {31'd0, drain_err}, 32'd0);
            if (k == 16) chk("tmo_err_at", {31'd0, drain_err}, 32'd1);
        end
        chk("tmo_busy", {31'd0, busy}, 32'd1);
        pipe_clear = 1'b1;
        tick();
        chk("tmo_commit_intr", {31'd0, intr}, 32'd1);
        tick();
        chk("tmo_err_sticky", {31'd0, drain_err}, 32'd1);

        // Reset in the middle of a drain
        pipe_clear = 1'b0; exc_valid = 1'b1; exc_cause = 4'd3; exc_tval = 32'h55;
        tick();
        exc_valid = 1'b0;
        tick();
        nRST = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, drain_err}, 32'd0);
        chk("mid_rst_mtval", mtval_o, 32'd0);
        pipe_clear = 1'b1;
        tick();
        nRST = 1'b1;
        n_intr = 0;
        for (int i = 0; i < 4; i++) begin
            n_intr += int'(intr);
            tick();
        end
        chk("mid_rst_no_intr", n_intr, 0);
        chk("mid_rst_mcause", mcause_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
